fetch_buffer: RTL and testbench
===============================

FETCH_BUFFER -- requirements
Module: fetch_buffer

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock, all state on rising edge.
REQ-002 SHALL have: reset_n  in  1  asynchronous, active-low reset.
REQ-003 SHALL have: entry  in  64  start RIP, sampled while reset_n=0.
REQ-004 SHALL have: reqcyc  out  1 / req  out  64 / reqack  in  1  line-read request handshake.
REQ-005 SHALL have: respcyc  in  1 / resp  in  64 / respack  out  1  response beat handshake.
REQ-006 SHALL have: redirect  in  1 / redirect_rip  in  64  flush and refetch.
REQ-007 SHALL have: win_bytes  out  120  15-byte decode window, byte 0 in bits [119:112]; win_valid  out  1.
REQ-008 SHALL have: consume  in  4  bytes retired by decode this cycle.
REQ-009 SHALL have: perf_lines  out  32 / perf_starve  out  32  performance counters.

Function
REQ-010 SHALL hold a 128-byte circular buffer, 7-bit read pointer rd_ptr, 7-bit beat-aligned write pointer wr_ptr, 8-bit byte count cnt.
REQ-011 SHALL run FSM IDLE, REQ, WAIT, ACTIVE, DRAIN; IDLE->REQ when cnt<=64 and no redirect.
REQ-012 SHALL in REQ drive reqcyc=1, req=line address (rip & ~63), held stable until reqack=1, then ->WAIT.
REQ-013 SHALL drive respack=respcyc combinationally.
REQ-014 SHALL on first respcyc beat in WAIT ->ACTIVE; 3-bit beat counter; after 8th beat ->IDLE, line address +=64.
REQ-015 SHALL discard beats whose index < skip (skip=rip[5:3] for first line after reset/redirect, 0 otherwise).
REQ-016 SHALL write each kept beat to buffer[wr_ptr+:8], wr_ptr+=8 (mod 128), cnt+=8, except first kept beat after reset/redirect adds 8-rip[2:0] with rd_ptr preloaded to rip[2:0].
REQ-017 SHALL assert win_valid when cnt>=15; win_bytes = buffer[rd_ptr..rd_ptr+14] with wrap mod 128.
REQ-018 SHALL honour consume only when win_valid=1: rd_ptr+=consume, cnt-=consume; consume>cnt is a bench fatal error.
REQ-019 SHALL update cnt as cnt+written-consumed when beat and consume coincide.
REQ-020 SHALL on redirect: cnt=0, rip=redirect_rip, wr_ptr=0, rd_ptr=redirect_rip[2:0]; from IDLE/REQ ->IDLE (drop reqcyc next cycle); from WAIT/ACTIVE ->DRAIN.
REQ-021 SHALL in DRAIN accept and discard remaining beats of outstanding line, then ->IDLE; beat coinciding with redirect is discarded and counted.
REQ-022 SHALL give redirect priority over consume and beat write in the same cycle.
REQ-023 SHALL never overflow: cnt<=64 at request guarantees 64 free bytes.

Reset
REQ-024 SHALL on reset_n=0 set: FSM=IDLE, reqcyc=0, req=0, win_valid=0, win_bytes=0, cnt=0, wr_ptr=0, rd_ptr=entry[2:0], skip=entry[5:3], line address=entry&~63, buffer=0, perf counters=0.
REQ-025 SHALL abandon any outstanding line on mid-operation reset; the bus side owns its own recovery.

Configuration
REQ-026 SHALL, with FETCH_PERF_CNT_EN defined, increment perf_lines per completed line (8th beat, non-DRAIN) and perf_starve per cycle win_valid=0, both wrap at 2^32.
REQ-027 SHALL, without FETCH_PERF_CNT_EN, keep both ports present and tied to 0 with no counter logic.

Verification
REQ-028 Reset with entry=0x1000, memory returns 8 beats -> req=0x1000, cnt=64, win_valid=1, win_bytes = bytes 0x1000..0x100E.
REQ-029 entry=0x102B -> beats 0..4 discarded, first kept beat adds 5 bytes, rd_ptr=3, win_bytes begins at byte 0x102B.
REQ-030 Consume 15 every cycle, reqack delayed 10 cycles -> reqcyc/req stable throughout, window wraps across byte 127->0 correctly, perf_starve counts starved cycles.
REQ-031 redirect to 0x2000 during beat 3 of ACTIVE -> beats 3..7 discarded, cnt=0, next req=0x2000, no stale bytes in window.
REQ-032 cnt=60 with no consume -> one request, cnt=124, no further request until cnt<=64.
REQ-033 Assert reset_n=0 mid-ACTIVE -> all outputs at reset values same cycle (asynchronous), FSM IDLE after release.

Source files
------------

// File: rtl/fetch_buffer_if.sv
// Line-read request / response-beat bus between fetch_buffer (master) and the memory side (slave).
interface fetch_buffer_if;
   logic        reqcyc;
   logic [63:0] req;
   logic        reqack;
   logic        respcyc;
   logic [63:0] resp;
   logic        respack;

   modport master (output reqcyc, req, respack, input reqack, respcyc, resp);
   modport slave  (input reqcyc, req, respack, output reqack, respcyc, resp);
endinterface

// File: rtl/fetch_buffer.sv
// Instruction fetch buffer: 128-byte ring filled by 64-byte line reads, exposes a 15-byte decode window.
// Optional feature macro: FETCH_PERF_CNT_EN enables the perf_lines / perf_starve counters.

module fetch_buffer_lane #(
   parameter int OFS = 0
) (
   input  logic [127:0][7:0] ring,
   input  logic [6:0]        rd_ptr,
   output logic [7:0]        lane_byte
);
   assign lane_byte = ring[rd_ptr + 7'(OFS)];
endmodule

module fetch_buffer (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic [63:0]           entry,
   fetch_buffer_if.master        bus,
   input  logic                  redirect,
   input  logic [63:0]           redirect_rip,
   output logic [119:0]          win_bytes,
   output logic                  win_valid,
   input  logic [3:0]            consume,
   output logic [31:0]           perf_lines,
   output logic [31:0]           perf_starve
);
   localparam int WIN_BYTES  = 15;
   localparam int BEAT_BYTES = 8;

   typedef enum logic [2:0] {IDLE, REQ, WAIT, ACTIVE, DRAIN} state_t;

   state_t            state_q, state_d;
   logic [57:0]       line_q, line_d;
   logic [2:0]        beat_q, beat_d;
   logic [2:0]        skip_q, skip_d;
   logic [2:0]        ofs_q, ofs_d;
   logic              first_q, first_d;
   logic [6:0]        rd_ptr_q, rd_ptr_d;
   logic [6:0]        wr_ptr_q, wr_ptr_d;
   logic [7:0]        cnt_q, cnt_d;
   logic [127:0][7:0] ring_q;
   logic              wr_en;
   logic              line_done;
   logic [7:0]        eaten;
   logic [7:0]        added;

   assign win_valid   = (cnt_q >= 8'(WIN_BYTES));
   assign eaten       = win_valid ? {4'd0, consume} : 8'd0;
   // The first kept beat is written whole; bytes below the start RIP sit behind rd_ptr and never count.
   assign added       = first_q ? (8'd8 - {5'd0, ofs_q}) : 8'd8;

   assign bus.reqcyc  = (state_q == REQ);
   assign bus.req     = bus.reqcyc ? {line_q, 6'd0} : 64'd0;
   assign bus.respack = bus.respcyc;

   always_comb begin
      state_d   = state_q;
      line_d    = line_q;
      beat_d    = beat_q;
      skip_d    = skip_q;
      ofs_d     = ofs_q;
      first_d   = first_q;
      rd_ptr_d  = rd_ptr_q + eaten[6:0];
      wr_ptr_d  = wr_ptr_q;
      wr_en     = 1'b0;
      line_done = 1'b0;
      case (state_q)
         IDLE:
            if (!redirect && cnt_q <= 8'd64) state_d = REQ;
         REQ:
            // An acknowledged request that meets a redirect still owes us 8 beats, so drain them.
            if (bus.reqack) begin
               beat_d  = '0;
               state_d = redirect ? DRAIN : WAIT;
            end else if (redirect) begin
               state_d = IDLE;
            end
         WAIT, ACTIVE:
            if (bus.respcyc) begin
               beat_d = beat_q + 3'd1;
               wr_en  = !redirect && (beat_q >= skip_q);
               if (beat_q == 3'd7) begin
                  state_d   = IDLE;
                  line_done = !redirect;
               end else begin
                  state_d = redirect ? DRAIN : ACTIVE;
               end
            end else if (redirect) begin
               state_d = DRAIN;
            end
         DRAIN:
            if (bus.respcyc) begin
               beat_d = beat_q + 3'd1;
               if (beat_q == 3'd7) state_d = IDLE;
            end
         default: state_d = IDLE;
      endcase

      if (line_done) begin
         line_d = line_q + 58'd1;
         skip_d = '0;
      end
      if (wr_en) begin
         wr_ptr_d = wr_ptr_q + 7'(BEAT_BYTES);
         first_d  = 1'b0;
      end
      cnt_d = cnt_q + (wr_en ? added : 8'd0) - eaten;

      if (redirect) begin
         cnt_d    = '0;
         wr_ptr_d = '0;
         rd_ptr_d = {4'd0, redirect_rip[2:0]};
         line_d   = redirect_rip[63:6];
         skip_d   = redirect_rip[5:3];
         ofs_d    = redirect_rip[2:0];
         first_d  = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= IDLE;
         line_q   <= entry[63:6];
         beat_q   <= '0;
         skip_q   <= entry[5:3];
         ofs_q    <= entry[2:0];
         first_q  <= 1'b1;
         rd_ptr_q <= {4'd0, entry[2:0]};
         wr_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         state_q  <= state_d;
         line_q   <= line_d;
         beat_q   <= beat_d;
         skip_q   <= skip_d;
         ofs_q    <= ofs_d;
         first_q  <= first_d;
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         cnt_q    <= cnt_d;
      end
   end

   // Beat byte k (resp[8k+:8]) is the byte at line address + 8*beat + k.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ring_q <= '0;
      end else if (wr_en) begin
         for (int k = 0; k < BEAT_BYTES; k++)
            ring_q[wr_ptr_q + 7'(k)] <= bus.resp[8*k +: 8];
      end
   end

   for (genvar i = 0; i < WIN_BYTES; i++) begin : g_win
      fetch_buffer_lane #(.OFS(i)) u_lane (
         .ring      (ring_q),
         .rd_ptr    (rd_ptr_q),
         .lane_byte (win_bytes[119-8*i -: 8])
      );
   end

`ifdef FETCH_PERF_CNT_EN
   logic [31:0] lines_q, starve_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         lines_q  <= '0;
         starve_q <= '0;
      end else begin
         if (line_done)  lines_q  <= lines_q + 32'd1;
         if (!win_valid) starve_q <= starve_q + 32'd1;
      end
   end

   assign perf_lines  = lines_q;
   assign perf_starve = starve_q;
`else
   assign perf_lines  = '0;
   assign perf_starve = '0;
`endif

endmodule

// File: tb/tb_fetch_buffer.sv
// Scoreboard bench for fetch_buffer: memory model answers line reads; monitors check requests and window.
module tb_fetch_buffer;
   logic         clk = 1'b0;
   logic         reset_n = 1'b0;
   logic [63:0]  entry = 64'd0;
   logic         redirect = 1'b0;
   logic [63:0]  redirect_rip = 64'd0;
   logic [119:0] win_bytes;
   logic         win_valid;
   logic [3:0]   consume = 4'd0;
   logic [31:0]  perf_lines, perf_starve;

   fetch_buffer_if bus();

   fetch_buffer dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .entry        (entry),
      .bus          (bus),
      .redirect     (redirect),
      .redirect_rip (redirect_rip),
      .win_bytes    (win_bytes),
      .win_valid    (win_valid),
      .consume      (consume),
      .perf_lines   (perf_lines),
      .perf_starve  (perf_starve)
   );

   always #5 clk = ~clk;

   int          checks = 0;
   int          failures = 0;
   logic [63:0] exp_req_q[$];
   logic [63:0] exp_rip = 64'd0;
   int          ack_delay = 0;
   int          req_seen = 0;
   int          mem_idx = 0;
   int          ack_cnt = 0;
   int          beats_left = 0;
   logic [63:0] cur_line = 64'd0;
   int          starve = 0;

   function automatic logic [7:0] mb(input logic [63:0] a);
      return a[7:0] ^ {a[11:8], a[15:12]} ^ 8'h5A;
   endfunction

   function automatic logic [63:0] beat_data(input logic [63:0] line, input int idx);
      logic [63:0] d;
      for (int k = 0; k < 8; k++) d[8*k +: 8] = mb(line + 64'(8*idx + k));
      return d;
   endfunction

   function automatic logic [119:0] exp_win(input logic [63:0] a);
      logic [119:0] w;
      for (int i = 0; i < 15; i++) w[119-8*i -: 8] = mb(a + 64'(i));
      return w;
   endfunction

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   // Memory model: acks after ack_delay cycles of reqcyc, then streams 8 beats back to back.
   initial begin
      bus.reqack  = 1'b0;
      bus.respcyc = 1'b0;
      bus.resp    = 64'd0;
      forever begin
         @(posedge clk); #1;
         bus.reqack  = 1'b0;
         bus.respcyc = 1'b0;
         if (!reset_n) begin
            ack_cnt    = 0;
            beats_left = 0;
         end else if (beats_left > 0) begin
            mem_idx     = 8 - beats_left;
            bus.respcyc = 1'b1;
            bus.resp    = beat_data(cur_line, mem_idx);
            beats_left--;
         end else if (bus.reqcyc) begin
            if (ack_cnt >= ack_delay) begin
               bus.reqack = 1'b1;
               cur_line   = bus.req;
               beats_left = 8;
               ack_cnt    = 0;
            end else begin
               ack_cnt++;
            end
         end else begin
            ack_cnt = 0;
         end
      end
   end

   // Request monitor: every cycle of reqcyc must show the scoreboard head; pop on handshake.
   always @(negedge clk) begin
      if (reset_n) begin
         chk("respack", bus.respack, bus.respcyc);
         if (bus.reqcyc) begin
            if (exp_req_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_req actual=%0h required=none", bus.req);
            end else begin
               chk("req_addr", bus.req, exp_req_q[0]);
               if (bus.reqack) begin
                  void'(exp_req_q.pop_front());
                  req_seen++;
               end
            end
         end
      end
   end

   // Window monitor: a valid window must be the 15 bytes starting at the model's RIP.
   always @(negedge clk) begin
      if (reset_n && win_valid) chk("window", win_bytes, exp_win(exp_rip));
   end

   task automatic do_reset(input logic [63:0] e);
      reset_n  = 1'b0;
      entry    = e;
      redirect = 1'b0;
      consume  = 4'd0;
      exp_req_q.delete();
      exp_rip  = e;
      repeat (2) @(posedge clk);
      #2;
      chk("rst_reqcyc", bus.reqcyc, 0);
      chk("rst_req", bus.req, 0);
      chk("rst_win_valid", win_valid, 0);
      chk("rst_win_bytes", win_bytes, 0);
      chk("rst_perf_lines", perf_lines, 0);
      chk("rst_perf_starve", perf_starve, 0);
      chk("rst_rd_ptr", dut.rd_ptr_q, e[2:0]);
      reset_n = 1'b1;
   endtask

   task automatic settle(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   task automatic wait_req(input logic [63:0] a, input string nm);
      bit hit = 1'b0;
      for (int i = 0; i < 200 && !hit; i++) begin
         @(posedge clk); #2;
         if (bus.reqcyc && bus.req == a) hit = 1'b1;
      end
      chk(nm, hit, 1);
   endtask

   task automatic wait_valid(input string nm);
      bit hit = 1'b0;
      for (int i = 0; i < 200 && !hit; i++) begin
         @(posedge clk); #2;
         if (win_valid) hit = 1'b1;
      end
      chk(nm, hit, 1);
   endtask

   task automatic wait_beat(input int idx, input string nm);
      bit hit = 1'b0;
      for (int i = 0; i < 200 && !hit; i++) begin
         @(posedge clk); #2;
         if (bus.respcyc && mem_idx == idx) hit = 1'b1;
      end
      chk(nm, hit, 1);
   endtask

   initial begin
      // Aligned entry: one full line, then a second request at cnt=64 fills the ring.
      ack_delay = 0;
      do_reset(64'h1000);
      exp_req_q.push_back(64'h1000);
      exp_req_q.push_back(64'h1040);
      wait_req(64'h1040, "t1_second_req");
      chk("t1_cnt_after_line", dut.cnt_q, 64);
      chk("t1_first_byte", win_bytes[119:112], mb(64'h1000));
      settle(30);
      chk("t1_cnt_full", dut.cnt_q, 128);
      chk("t1_reqs_done", exp_req_q.size(), 0);

      // Unaligned entry: beats 0..4 skipped, first kept beat counts 5 bytes.
      do_reset(64'h102B);
      exp_req_q.push_back(64'h1000);
      exp_req_q.push_back(64'h1040);
      wait_valid("t2_valid");
      chk("t2_first_byte", win_bytes[119:112], mb(64'h102B));
      settle(40);
      chk("t2_cnt", dut.cnt_q, 85);
      chk("t2_rd_ptr", dut.rd_ptr_q, 3);
      chk("t2_reqs_done", exp_req_q.size(), 0);

      // Streaming with slow reqack and full-rate consumption; window wraps the ring.
      ack_delay = 10;
      do_reset(64'h1000);
      for (int k = 0; k < 40; k++) exp_req_q.push_back(64'h1000 + 64'(64*k));
      req_seen = 0;
      starve   = 0;
      for (int c = 0; c < 300; c++) begin
         @(posedge clk); #2;
         exp_rip = exp_rip + 64'(consume);
         if (!win_valid) starve++;
         consume = win_valid ? 4'd15 : 4'd0;
      end
      @(posedge clk); #2;
      exp_rip = exp_rip + 64'(consume);
      consume = 4'd0;
      chk("t3_lines", req_seen >= 10, 1);
      chk("t3_wrapped", exp_rip >= 64'h1000 + 64'd384, 1);
      chk("t3_starved", starve > 0, 1);
`ifdef FETCH_PERF_CNT_EN
      chk("t3_perf_starve", perf_starve != 0, 1);
      chk("t3_perf_lines", perf_lines >= 32'd10, 1);
`else
      chk("t3_perf_lines_off", perf_lines, 0);
      chk("t3_perf_starve_off", perf_starve, 0);
`endif

      // Redirect during beat 3: rest of line drained, refetch from 0x2000.
      ack_delay = 0;
      do_reset(64'h1000);
      exp_req_q.push_back(64'h1000);
      wait_beat(3, "t4_beat3");
      redirect     = 1'b1;
      redirect_rip = 64'h2000;
      @(posedge clk); #2;
      redirect = 1'b0;
      exp_rip  = 64'h2000;
      exp_req_q.push_back(64'h2000);
      exp_req_q.push_back(64'h2040);
      chk("t4_cnt_zero", dut.cnt_q, 0);
      chk("t4_win_invalid", win_valid, 0);
      wait_req(64'h2000, "t4_refetch_req");
      wait_valid("t4_valid");
      chk("t4_first_byte", win_bytes[119:112], mb(64'h2000));
      settle(30);
      chk("t4_cnt", dut.cnt_q, 128);
      chk("t4_reqs_done", exp_req_q.size(), 0);

      // 60 bytes after the first line: exactly one more request, then stop at 124.
      do_reset(64'h1004);
      exp_req_q.push_back(64'h1000);
      exp_req_q.push_back(64'h1040);
      settle(60);
      chk("t5_cnt", dut.cnt_q, 124);
      chk("t5_reqs_done", exp_req_q.size(), 0);
      chk("t5_no_req", bus.reqcyc, 0);

      // Asynchronous reset in the middle of a line.
      do_reset(64'h1000);
      exp_req_q.push_back(64'h1000);
      wait_beat(2, "t6_beat2");
      #1;
      reset_n = 1'b0;
      #1;
      chk("t6_async_reqcyc", bus.reqcyc, 0);
      chk("t6_async_req", bus.req, 0);
      chk("t6_async_win_valid", win_valid, 0);
      chk("t6_async_win_bytes", win_bytes, 0);
      do_reset(64'h3000);
      exp_req_q.push_back(64'h3000);
      exp_req_q.push_back(64'h3040);
      chk("t6_idle_after_release", bus.reqcyc, 0);
      wait_valid("t6_valid");
      chk("t6_first_byte", win_bytes[119:112], mb(64'h3000));
      settle(30);
      chk("t6_reqs_done", exp_req_q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #500000;
      failures++;
      $display("FAIL watchdog actual=timeout required=finish");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog");
   end
endmodule
